nor16_1: RTL and testbench

- 16-input NOR reduction block: `out` is asserted exactly when all 16 input bits are zero.
- Used as the leaf of the ALU zero-flag detector. Four instances cover a 64-bit result and feed a 4-input AND.
- Also provides per-nibble zero indications and a registered copy of the result for pipelined consumers.

---
 rtl/nor16_1.sv | 32 +++
 tb/tb_nor16_1.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/nor16_1.sv
// rtl/nor16_1.sv - 16-input NOR reduction with per-nibble zero flags and registered result
`timescale 1ns/10ps

module nor16_1 #(
  parameter real DELAY = 0.05
) (
  input  logic        clk,
  input  logic        reset,
  output logic        out,
  input  logic [15:0] in,
  output logic [3:0]  nibble_zero,
  output logic        out_q
);

  // Level 1: one 4-input NOR per nibble; a known 1 anywhere in the nibble forces 0
  for (genvar i = 0; i < 4; i++) begin : g_nibble
    nor #(DELAY) u_nor (nibble_zero[i], in[4*i], in[4*i+1], in[4*i+2], in[4*i+3]);
  end

  // Level 2: the word is zero only when every nibble is zero
  and #(DELAY) u_and (out, nibble_zero[0], nibble_zero[1], nibble_zero[2], nibble_zero[3]);

  // Pipelined copy of the zero result; reset clears it without waiting for clk
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q <= 1'b0;
    end else begin
      out_q <= out;
    end
  end

endmodule

// File: tb/tb_nor16_1.sv
// tb/tb_nor16_1.sv - randomized self-checking bench for nor16_1
`timescale 1ns/10ps

module tb_nor16_1;

  logic        clk;
  logic        reset;
  logic        out;
  logic [15:0] in;
  logic [3:0]  nibble_zero;
  logic        out_q;

  int checks;
  int errors;

  nor16_1 dut (
    .clk        (clk),
    .reset      (reset),
    .out        (out),
    .in         (in),
    .nibble_zero(nibble_zero),
    .out_q      (out_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: word is zero iff its unsigned value is 0
  function automatic logic ref_out(input logic [15:0] v);
    return (int'(v) == 0);
  endfunction

  // Reference: nibble i is zero iff (v / 16^i) mod 16 == 0
  function automatic logic [3:0] ref_nz(input logic [15:0] v);
    logic [3:0] r;
    int w;
    r = '0;
    w = int'(v);
    for (int i = 0; i < 4; i++) begin
      r[i] = ((w % 16) == 0);
      w = w / 16;
    end
    return r;
  endfunction

  // Drive a vector, check the combinational outputs once settled, then the registered copy
  task automatic apply(input logic [15:0] v, input string tag);
    in = v;
    #1;
    check({tag, ".out"}, {15'd0, out}, {15'd0, ref_out(v)});
    check({tag, ".nz"}, {12'd0, nibble_zero}, {12'd0, ref_nz(v)});
    @(posedge clk);
    #1;
    check({tag, ".out_q"}, {15'd0, out_q}, {15'd0, ref_out(v)});
  endtask

  initial begin
    logic [15:0] v;
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    in     = 16'h0000;

    // Reset state: out_q held at 0 across clock edges, out tracks in
    repeat (2) @(posedge clk);
    #1;
    check("reset.out_q", {15'd0, out_q}, 16'd0);
    check("reset.out", {15'd0, out}, 16'd1);
    check("reset.nz", {12'd0, nibble_zero}, 16'h000F);
    @(negedge clk);
    reset = 1'b0;

    // Directed vectors
    apply(16'h0000, "zero");
    apply(16'h027C, "h027c");
    apply(16'h0001, "h0001");
    apply(16'h8000, "h8000");

    // Walking one, then all ones
    for (int b = 0; b < 16; b++) begin
      v = 16'h0001 << b;
      apply(v, $sformatf("walk%0d", b));
    end
    apply(16'hFFFF, "ffff");

    // Async reset mid-cycle with in = 0
    apply(16'h0000, "pre_rst");
    @(posedge clk);
    #3;
    reset = 1'b1;
    #0.5;
    check("rst_async.out_q", {15'd0, out_q}, 16'd0);
    check("rst_async.out", {15'd0, out}, 16'd1);
    @(posedge clk);
    #1;
    check("rst_hold.out_q", {15'd0, out_q}, 16'd0);
    #2;
    reset = 1'b0;
    #1;
    check("rst_release.out_q", {15'd0, out_q}, 16'd0);
    @(posedge clk);
    #1;
    check("rst_capture.out_q", {15'd0, out_q}, 16'd1);

    // Propagation timing: 0x0000 -> 0x0010
    @(negedge clk);
    in = 16'h0010;
    #0.03;
    check("tim.nz_early", {12'd0, nibble_zero}, 16'h000F);
    #0.04;
    check("tim.out_early", {15'd0, out}, 16'd1);
    check("tim.nz_mid", {12'd0, nibble_zero}, 16'h000D);
    #0.05;
    check("tim.out_late", {15'd0, out}, 16'd0);
    in = 16'h0000;
    #10;
    check("tim.out_10ns", {15'd0, out}, 16'd1);
    in = 16'h0010;
    #10;
    check("tim.out_20ns", {15'd0, out}, 16'd0);

    // Random vectors, biased towards zero and sparse words
    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(3))
        0: v = 16'h0000;
        1: v = 16'h0001 << $urandom_range(15);
        2: v = 16'($urandom) & (16'h000F << (4 * $urandom_range(3)));
        default: v = 16'($urandom);
      endcase
      apply(v, $sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
